uart_tx_arbiter: RTL

Sequences and shares the single UART transmitter between NUM_REQ byte requesters, for example the RX echo path and the switch-entry path. It performs round-robin arbitration and latches the winning byte. It then drives the transmitter's send/data/bussy handshake across the slow baud-clock boundary. It sits between the requesters and the Tx instance, replacing the direct push-button drive of send.

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte sources.
// Drives the Tx send/data/bussy handshake; bussy is resynchronised here.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic                      src_clk,
    input  logic                      rst,
    input  logic                      tx_enable,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx_send,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_bussy,
    output logic                      busy,
    output logic [2:0]                last_src,
    output logic                      err_timeout
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_bsy_m, r_bsy_s;
    logic [PW-1:0]       r_ptr, w_ptr_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic                r_send, w_send_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic                r_busy, w_busy_nxt;
    logic [2:0]          r_last, w_last_nxt;
    logic                r_err, w_err_nxt;
    logic                w_found;
    logic [PW-1:0]       w_win;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p,
                                             input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Scan downward so the requester closest to the pointer is kept last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = '0;
        w_send_nxt  = r_send;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (tx_enable && w_found && !r_bsy_s) begin
                    w_gnt_nxt[w_win] = 1'b1;
                    w_data_nxt  = req_data[int'(w_win)*DATA_W +: DATA_W];
                    w_last_nxt  = 3'(w_win);
                    w_ptr_nxt   = (w_win == PW'(NUM_REQ - 1)) ? '0
                                : w_win + PW'(1);
                    w_send_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (r_bsy_s) begin
                    w_send_nxt  = 1'b0;
                    w_state_nxt = DRAIN;
                end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    w_send_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (!r_bsy_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bsy_m <= 1'b0;
            r_bsy_s <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_send  <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_last  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bsy_m <= tx_bussy;
            r_bsy_s <= r_bsy_m;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_send  <= w_send_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign tx_send     = r_send;
    assign tx_data     = r_data;
    assign busy        = r_busy;
    assign last_src    = r_last;
    assign err_timeout = r_err;

endmodule
